// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Brief    : MIPS coprocessor 0 at the M stage. Decodes MFC0/MTC0/ERET,
//            holds SR/Cause/EPC/PRId/Count/Compare and raises the
//            interrupt/exception flush request.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
  parameter int          HW_INT_NUM = 6,
  parameter bit          TIMER_EN   = 1'b1,
  parameter logic [31:0] PRID       = 32'h0000_4D50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Instr,
  input  logic [31:0]           WData,
  input  logic [31:0]           PC,
  input  logic                  InDelaySlot,
  input  logic [4:0]            ExcCodeIn,
  input  logic [HW_INT_NUM-1:0] HWInt,
  output logic [31:0]           RData,
  output logic                  MResultSel,
  output logic                  IsERET,
  output logic                  IntReq,
  output logic [31:0]           EPCOut
);

  localparam logic [4:0] c_REG_COUNT   = 5'd9;
  localparam logic [4:0] c_REG_COMPARE = 5'd11;
  localparam logic [4:0] c_REG_SR      = 5'd12;
  localparam logic [4:0] c_REG_CAUSE   = 5'd13;
  localparam logic [4:0] c_REG_EPC     = 5'd14;
  localparam logic [4:0] c_REG_PRID    = 5'd15;

  // Architectural state (only the defined fields are stored)
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;
  logic [7:0]  ip_q, ip_d;
  logic [29:0] epc_q, epc_d;

  logic        w_cop0, w_is_mfc0, w_is_mtc0, w_is_eret, w_mtc0_we;
  logic [4:0]  w_sel;
  logic [7:0]  w_ip_live;
  logic        w_int_pend, w_exc_pend;
  logic [31:0] w_epc_target;
  logic [31:0] w_count, w_compare;
  logic        w_ti;
  logic        w_unused_ok;

  assign w_cop0    = (Instr[31:26] == 6'b010000);
  assign w_is_mfc0 = w_cop0 && (Instr[25:21] == 5'b00000);
  assign w_is_mtc0 = w_cop0 && (Instr[25:21] == 5'b00100);
  assign w_is_eret = w_cop0 && Instr[25] && (Instr[5:0] == 6'b011000);
  assign w_sel     = Instr[15:11];

  // A flushed instruction must not commit its CP0 write
  assign w_mtc0_we = w_is_mtc0 && !IntReq;

  assign MResultSel = w_is_mfc0;
  assign IsERET     = w_is_eret;
  assign EPCOut     = {epc_q, 2'b00};

  assign w_epc_target = InDelaySlot ? (PC - 32'd4) : PC;
  assign w_unused_ok  = &{1'b0, Instr[20:16], Instr[10:6], w_epc_target[1:0]};

  // Next IP value: external lines at IP[2+i], timer ORed into IP[7]
  always_comb begin
    w_ip_live = '0;
    for (int i = 0; i < HW_INT_NUM; i++) begin
      w_ip_live[2+i] = HWInt[i];
    end
    w_ip_live[7] = w_ip_live[7] | w_ti;
  end

  assign w_int_pend = (|(w_ip_live & im_q)) && ie_q && !exl_q;
  assign w_exc_pend = (ExcCodeIn != 5'd0) && !exl_q;
  assign IntReq     = w_int_pend || w_exc_pend;

  // MFC0 read mux
  always_comb begin
    RData = '0;
    case (w_sel)
      c_REG_COUNT:   RData = w_count;
      c_REG_COMPARE: RData = w_compare;
      c_REG_SR:      RData = {16'd0, im_q, 6'd0, exl_q, ie_q};
      c_REG_CAUSE:   RData = {bd_q, w_ti, 14'd0, ip_q, 1'b0, exc_q, 2'b00};
      c_REG_EPC:     RData = {epc_q, 2'b00};
      c_REG_PRID:    RData = PRID;
      default:       RData = '0;
    endcase
  end

  // Next-state for SR/Cause/EPC: exception entry beats ERET beats MTC0
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = w_ip_live;
    if (IntReq) begin
      exl_d = 1'b1;
      epc_d = w_epc_target[31:2];
      bd_d  = InDelaySlot;
      exc_d = w_int_pend ? 5'd0 : ExcCodeIn;
    end else if (w_is_eret) begin
      exl_d = 1'b0;
    end else if (w_mtc0_we) begin
      case (w_sel)
        c_REG_SR: begin
          im_d  = WData[15:8];
          exl_d = WData[1];
          ie_d  = WData[0];
        end
        c_REG_EPC: epc_d = WData[31:2];
        default:   ;
      endcase
    end
  end

  // SR/Cause/EPC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      ip_q  <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      logic [31:0] count_q, count_d;
      logic [31:0] compare_q, compare_d;
      logic        ti_q, ti_d;
      logic        w_cmp_wr;

      assign w_cmp_wr = w_mtc0_we && (w_sel == c_REG_COMPARE);

      // Free-running counter; a Compare write clears TI even on a match
      always_comb begin
        count_d   = (w_mtc0_we && (w_sel == c_REG_COUNT)) ? WData : count_q + 32'd1;
        compare_d = w_cmp_wr ? WData : compare_q;
        ti_d      = ti_q;
        if (w_cmp_wr) begin
          ti_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
          ti_d = 1'b1;
        end
      end

      // Timer registers
      always_ff @(posedge clk) begin
        if (reset) begin
          count_q   <= '0;
          compare_q <= '0;
          ti_q      <= 1'b0;
        end else begin
          count_q   <= count_d;
          compare_q <= compare_d;
          ti_q      <= ti_d;
        end
      end

      assign w_count   = count_q;
      assign w_compare = compare_q;
      assign w_ti      = ti_q;
    end else begin : g_no_timer
      assign w_count   = '0;
      assign w_compare = '0;
      assign w_ti      = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Brief    : Self-checking bench for cp0_unit (HW_INT_NUM=6, TIMER_EN=1):
//            directed scenarios followed by random traffic, all compared
//            against a register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr, WData, PC;
  logic        InDelaySlot;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic [31:0] RData, EPCOut;
  logic        MResultSel, IsERET, IntReq;

  always #5 clk = ~clk;

  cp0_unit #(.HW_INT_NUM(6), .TIMER_EN(1'b1), .PRID(32'h0000_4D50)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .WData(WData), .PC(PC),
    .InDelaySlot(InDelaySlot), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .RData(RData), .MResultSel(MResultSel), .IsERET(IsERET),
    .IntReq(IntReq), .EPCOut(EPCOut)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: whole 32-bit register images as software sees them
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_cmp;

  // Per-cycle side inputs and last observed outputs
  logic [31:0] g_pc;
  logic        g_ds;
  logic [4:0]  g_ec;
  logic [5:0]  g_hw;
  logic [31:0] obs_rdata, obs_epcout;
  logic        obs_int, obs_eret;

  localparam logic [31:0] c_NOP  = 32'h0000_0000;
  localparam logic [31:0] c_ERET = 32'h4200_0018;

  function automatic logic [31:0] mfc0(input logic [4:0] sel);
    return {6'b010000, 5'b00000, 5'd8, sel, 11'd0};
  endfunction

  function automatic logic [31:0] mtc0(input logic [4:0] sel);
    return {6'b010000, 5'b00100, 5'd8, sel, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] wd);
    logic        is_cop0, mf, mt, er, ti, ipend, epend, take, ti_n, bd_n;
    logic [4:0]  sel, exc_n;
    logic [7:0]  ip, im;
    logic [31:0] e_rd, n_sr, n_epc, n_cmp, n_cnt;
    reset = r; Instr = ins; WData = wd; PC = g_pc;
    InDelaySlot = g_ds; ExcCodeIn = g_ec; HWInt = g_hw;
    #3;
    is_cop0 = (ins[31:26] == 6'h10);
    sel = ins[15:11];
    mf  = is_cop0 && ins[25:21] == 5'd0;
    mt  = is_cop0 && ins[25:21] == 5'd4;
    er  = is_cop0 && ins[25] && ins[5:0] == 6'h18;
    ti  = m_cause[30];
    ip  = {g_hw[5] | ti, g_hw[4:0], 2'b00};
    im  = m_sr[15:8];
    ipend = ((ip & im) != 8'd0) && m_sr[0] && !m_sr[1];
    epend = (g_ec != 5'd0) && !m_sr[1];
    take  = ipend || epend;
    case (sel)
      5'd9:    e_rd = m_count;
      5'd11:   e_rd = m_cmp;
      5'd12:   e_rd = m_sr;
      5'd13:   e_rd = m_cause;
      5'd14:   e_rd = m_epc;
      5'd15:   e_rd = 32'h0000_4D50;
      default: e_rd = 32'd0;
    endcase
    obs_rdata = RData; obs_int = IntReq; obs_eret = IsERET; obs_epcout = EPCOut;
    chk("rdata", RData, e_rd);
    chk("mresultsel", 32'(MResultSel), 32'(mf));
    chk("iseret", 32'(IsERET), 32'(er));
    chk("intreq", 32'(IntReq), 32'(take));
    chk("epcout", EPCOut, m_epc);
    n_sr = m_sr; n_epc = m_epc; n_cmp = m_cmp; n_cnt = m_count + 32'd1;
    bd_n = m_cause[31]; exc_n = m_cause[6:2];
    if (take) begin
      n_sr  = m_sr | 32'h2;
      n_epc = (g_ds ? g_pc - 32'd4 : g_pc) & ~32'd3;
      bd_n  = g_ds;
      exc_n = ipend ? 5'd0 : g_ec;
    end else if (er) begin
      n_sr = m_sr & ~32'h2;
    end else if (mt) begin
      if (sel == 5'd12) n_sr  = wd & 32'h0000_FF03;
      if (sel == 5'd14) n_epc = wd & ~32'd3;
      if (sel == 5'd11) n_cmp = wd;
      if (sel == 5'd9)  n_cnt = wd;
    end
    if (mt && !take && sel == 5'd11)          ti_n = 1'b0;
    else if (m_count == m_cmp && m_cmp != 0)  ti_n = 1'b1;
    else                                      ti_n = ti;
    @(posedge clk);
    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_cmp = 0;
    end else begin
      m_sr = n_sr; m_epc = n_epc; m_cmp = n_cmp; m_count = n_cnt;
      m_cause = {bd_n, ti_n, 14'd0, ip, 1'b0, exc_n, 2'b00};
    end
    #1;
  endtask

  initial begin
    logic        int_seen;
    logic [31:0] ins, wd;
    logic [4:0]  rsel;
    int          k;
    reset = 1'b1; Instr = c_NOP; WData = 0; PC = 0; InDelaySlot = 0;
    ExcCodeIn = 0; HWInt = 0;
    g_pc = 32'h0000_1000; g_ds = 0; g_ec = 0; g_hw = 0;
    repeat (2) @(posedge clk);
    #1;
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_cmp = 0;

    // Reset state
    step(0, mfc0(5'd12), 0); chk("rst_sr", obs_rdata, 32'd0);
    step(0, mfc0(5'd13), 0); chk("rst_cause", obs_rdata, 32'd0);
    step(0, mfc0(5'd14), 0); chk("rst_epc", obs_rdata, 32'd0);

    // External interrupt
    g_hw = 6'h01;
    step(0, mtc0(5'd12), 32'h0000_0401);
    g_pc = 32'h0000_1000;
    step(0, c_NOP, 0);        chk("irq_take", 32'(obs_int), 32'd1);
    step(0, mfc0(5'd13), 0);  chk("irq_held", 32'(obs_int), 32'd0);
                              chk("irq_cause", obs_rdata, 32'h0000_0400);
    step(0, mfc0(5'd14), 0);  chk("irq_epc", obs_rdata, 32'h0000_1000);
    step(0, mfc0(5'd12), 0);  chk("irq_sr", obs_rdata, 32'h0000_0403);
    g_hw = 0;
    step(0, c_ERET, 0);

    // Exception in a delay slot
    g_ec = 5'd10; g_pc = 32'h0000_3010; g_ds = 1;
    step(0, c_NOP, 0);        chk("exc_take", 32'(obs_int), 32'd1);
    g_ec = 0; g_ds = 0;
    step(0, mfc0(5'd14), 0);  chk("exc_epc", obs_rdata, 32'h0000_300C);
    step(0, mfc0(5'd13), 0);  chk("exc_cause", obs_rdata, 32'h8000_0028);
    step(0, c_ERET, 0);

    // Interrupt beats exception; flushed MTC0 EPC
    g_hw = 6'h01; g_ec = 5'd4; g_pc = 32'h0000_2000;
    step(0, mtc0(5'd14), 32'hDEAD_0000);
    g_hw = 0; g_ec = 0;
    step(0, mfc0(5'd13), 0);  chk("prio_cause", obs_rdata, 32'h0000_0400);
    step(0, mfc0(5'd14), 0);  chk("prio_epc", obs_rdata, 32'h0000_2000);

    // ERET target
    step(0, mtc0(5'd14), 32'h0000_3020);
    step(0, c_ERET, 0);       chk("eret_flag", 32'(obs_eret), 32'd1);
                              chk("eret_target", obs_epcout, 32'h0000_3020);
    step(0, mfc0(5'd12), 0);  chk("eret_sr", obs_rdata, 32'h0000_0401);

    // Timer interrupt
    step(0, mtc0(5'd12), 32'h0000_8001);
    step(0, mtc0(5'd11), 32'd5);
    step(0, mtc0(5'd9), 32'd0);
    int_seen = 0;
    g_pc = 32'h0000_4000;
    for (int i = 0; i < 10; i++) begin
      step(0, c_NOP, 0);
      int_seen |= obs_int;
    end
    chk("timer_irq", 32'(int_seen), 32'd1);
    step(0, mfc0(5'd13), 0);  chk("ti_set", 32'(obs_rdata[30]), 32'd1);
    step(0, mtc0(5'd11), 32'd0);
    step(0, mfc0(5'd13), 0);  chk("ti_clr", 32'(obs_rdata[30]), 32'd0);
    step(0, c_ERET, 0);

    // Constant and read-only registers
    step(0, mfc0(5'd15), 0);  chk("prid", obs_rdata, 32'h0000_4D50);
    step(0, mfc0(5'd20), 0);  chk("unmapped", obs_rdata, 32'd0);
    step(0, mtc0(5'd13), 32'hFFFF_FFFF);
    step(0, mfc0(5'd13), 0);  chk("cause_ro", obs_rdata, 32'd0);

    // Reset overrides simultaneous write/exception
    g_hw = 6'h3F; g_ec = 5'd3;
    step(1, mtc0(5'd12), 32'h0000_0401);
    g_hw = 0; g_ec = 0;
    step(0, mfc0(5'd12), 0);  chk("rst_override", obs_rdata, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0: rsel = 5'd9;   1: rsel = 5'd11;  2: rsel = 5'd12;  3: rsel = 5'd13;
        4: rsel = 5'd14;  5: rsel = 5'd15;  6: rsel = 5'd20;
        default: rsel = 5'($urandom);
      endcase
      if (k < 3)       ins = mfc0(rsel);
      else if (k < 6)  ins = mtc0(rsel);
      else if (k == 6) ins = c_ERET;
      else             ins = {6'd0, 26'($urandom)};
      wd = $urandom;
      if (rsel == 5'd9 || rsel == 5'd11) wd = 32'($urandom_range(0, 40));
      g_pc = $urandom;
      g_ds = 1'($urandom);
      g_ec = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      g_hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      step(($urandom_range(0, 63) == 0), ins, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
